memory_bus_arbiter: RTL and testbench

//  Shares the single memory bus between the fetch stage (instruction reads) and the execute

---
 rtl/memory_bus_arbiter_pkg.sv | 52 +++++
 rtl/memory_bus_arbiter_if.sv | 34 +++
 rtl/memory_bus_arbiter_bus_watchdog.sv | 44 ++++
 rtl/memory_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_memory_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types for the fetch/execute memory bus arbiter.
// Owner and state encodings plus the latched bus transaction bundle.
package memory_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_FETCH = 2'd1,
        OWNER_EXEC  = 2'd2
    } arb_owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_txn_t;

    // Fetches are always word-aligned reads.
    function automatic bus_txn_t fetch_txn(input logic [ADDR_W-1:0] addr);
        bus_txn_t t;
        t.addr  = {addr[ADDR_W-1:2], 2'b00};
        t.write = 1'b0;
        t.wdata = '0;
        t.wstrb = '0;
        return t;
    endfunction

    function automatic bus_txn_t exec_txn(
        input logic [ADDR_W-1:0] addr,
        input logic              write,
        input logic [DATA_W-1:0] wdata,
        input logic [STRB_W-1:0] wstrb
    );
        bus_txn_t t;
        t.addr  = addr;
        t.write = write;
        t.wdata = write ? wdata : '0;
        t.wstrb = write ? wstrb : '0;
        return t;
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Memory bus seen by the arbiter (master) and the memory (slave).
// One transfer outstanding; bus_ready completes it.
interface memory_bus_arbiter_if;
    import memory_bus_arbiter_pkg::*;

    logic              bus_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_write;
    logic [DATA_W-1:0] bus_wdata;
    logic [STRB_W-1:0] bus_wstrb;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_valid,
        output bus_addr,
        output bus_write,
        output bus_wdata,
        output bus_wstrb,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_valid,
        input  bus_addr,
        input  bus_write,
        input  bus_wdata,
        input  bus_wstrb,
        output bus_ready,
        output bus_rdata
    );

endinterface

// File: rtl/memory_bus_arbiter_bus_watchdog.sv
// Counts cycles while start is high; expired flags the last allowed cycle.
// TIMEOUT=0 builds no counter and never expires.
module bus_watchdog #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    if (TIMEOUT > 0) begin : g_cnt
        localparam int CW = $clog2(TIMEOUT + 1);
        localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clear) begin
                cnt_d = '0;
            end else if (start && (cnt_q != LAST)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expired = start && (cnt_q == LAST);
    end else begin : g_none
        logic unused_wd;
        assign unused_wd = ^{clk, rst_n, start, clear};
        assign expired   = 1'b0;
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbitrates the memory bus between fetch and execute, one transfer at a time.
// Execute wins ties unless fetch has waited STARVE_LIMIT grants.
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 0
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    input  logic              e_req,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic              e_write,
    input  logic [DATA_W-1:0] e_wdata,
    input  logic [STRB_W-1:0] e_wstrb,
    output logic              e_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    memory_bus_arbiter_if.master bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    bus_txn_t          txn_q, txn_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              in_bus;
    logic              tmo_expired;
    logic              starved;

    assign in_bus  = (state_q == ARB_BUS);
    assign starved = (streak_q == STARVE_MAX);

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clock),
        .rst_n  (nreset),
        .start  (in_bus),
        .clear  (!in_bus),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        txn_d    = txn_q;
        streak_d = streak_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (e_req && (!f_req || !starved)) begin
                    owner_d = OWNER_EXEC;
                    txn_d   = exec_txn(e_addr, e_write, e_wdata, e_wstrb);
                    state_d = ARB_BUS;
                    // Exec is only chosen over a waiting fetch below the limit.
                    if (f_req) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (f_req) begin
                    owner_d  = OWNER_FETCH;
                    txn_d    = fetch_txn(f_addr);
                    state_d  = ARB_BUS;
                    streak_d = '0;
                end
            end
            ARB_BUS: begin
                if (bus.bus_ready) begin
                    rdata_d = txn_q.write ? '0 : bus.bus_rdata;
                    err_d   = 1'b0;
                    state_d = ARB_RESP;
                end else if (tmo_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                owner_d = OWNER_NONE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = OWNER_NONE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWNER_NONE;
            txn_q    <= '0;
            streak_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            txn_q    <= txn_d;
            streak_q <= streak_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // rdata_q/err_q are only non-zero during RESP.
    assign f_done        = (state_q == ARB_RESP) && (owner_q == OWNER_FETCH);
    assign e_done        = (state_q == ARB_RESP) && (owner_q == OWNER_EXEC);
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign bus.bus_valid = in_bus;
    assign bus.bus_addr  = txn_q.addr;
    assign bus.bus_write = txn_q.write;
    assign bus.bus_wdata = txn_q.wdata;
    assign bus.bus_wstrb = txn_q.wstrb;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed and random checks of memory_bus_arbiter against a
// transaction-level model of grant order, latched payload and response.
module tb_memory_bus_arbiter;

    localparam int LIM = 4;
    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        nreset;
    logic        f_req, e_req, e_write;
    logic [31:0] f_addr, e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic        f_done, e_done, err;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;
    int streak = 0;
    bit last_win_e;
    int last_cycles;
    bit [9:0] order;

    memory_bus_arbiter_if bus_if();

    memory_bus_arbiter #(
        .STARVE_LIMIT(LIM),
        .TIMEOUT(TMO)
    ) dut (
        .clock  (clock),
        .nreset (nreset),
        .f_req  (f_req),
        .f_addr (f_addr),
        .f_done (f_done),
        .e_req  (e_req),
        .e_addr (e_addr),
        .e_write(e_write),
        .e_wdata(e_wdata),
        .e_wstrb(e_wstrb),
        .e_done (e_done),
        .rdata  (rdata),
        .err    (err),
        .bus    (bus_if)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, bus_if.bus_valid, 0);
        chk({tag, "_fdone"}, f_done, 0);
        chk({tag, "_edone"}, e_done, 0);
    endtask

    // Called in an IDLE cycle with at least one request up;
    // returns in the RESP cycle with the winner's request dropped.
    task automatic xfer(input int lat, input bit scramble);
        bit          win_e, got_rdy, rdy;
        logic [31:0] x_addr, x_wdata, x_rd;
        logic        x_write, x_err;
        logic [3:0]  x_wstrb;
        int          c;
        chk_quiet("idle");
        win_e = e_req && (!f_req || streak < LIM);
        if (win_e) begin
            if (f_req) streak = (streak < LIM) ? streak + 1 : LIM;
            x_addr  = e_addr;
            x_write = e_write;
            x_wdata = e_write ? e_wdata : 32'h0;
            x_wstrb = e_write ? e_wstrb : 4'h0;
        end else begin
            streak  = 0;
            x_addr  = f_addr & ~32'h3;
            x_write = 1'b0;
            x_wdata = 32'h0;
            x_wstrb = 4'h0;
        end
        x_rd    = 32'h0;
        x_err   = 1'b1;
        got_rdy = 1'b0;
        c       = 0;
        step();
        while (!got_rdy && !(TMO > 0 && c == TMO) && c < 64) begin
            c++;
            chk("bus_valid", bus_if.bus_valid, 1);
            chk("bus_addr", bus_if.bus_addr, x_addr);
            chk("bus_write", bus_if.bus_write, x_write);
            chk("bus_wdata", bus_if.bus_wdata, x_wdata);
            chk("bus_wstrb", bus_if.bus_wstrb, x_wstrb);
            chk("bus_fdone", f_done, 0);
            chk("bus_edone", e_done, 0);
            if (scramble) begin
                if (win_e) begin
                    e_addr  = $urandom;
                    e_wdata = $urandom;
                    e_wstrb = 4'($urandom);
                    e_write = 1'($urandom);
                end else begin
                    f_addr = $urandom;
                end
            end
            rdy = (c == lat + 1);
            bus_if.bus_ready = rdy;
            bus_if.bus_rdata = $urandom;
            if (rdy) begin
                got_rdy = 1'b1;
                x_err   = 1'b0;
                x_rd    = x_write ? 32'h0 : bus_if.bus_rdata;
            end
            step();
        end
        bus_if.bus_ready = 1'b0;
        chk("resp_valid", bus_if.bus_valid, 0);
        chk("resp_edone", e_done, win_e);
        chk("resp_fdone", f_done, !win_e);
        chk("resp_rdata", rdata, x_rd);
        chk("resp_err", err, x_err);
        if (win_e) e_req = 1'b0;
        else f_req = 1'b0;
        last_win_e  = win_e;
        last_cycles = c;
    endtask

    initial begin
        nreset = 1'b0;
        f_req = 0; e_req = 0; e_write = 0;
        f_addr = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = 32'h0;
        step();
        step();
        chk_quiet("rst");
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", bus_if.bus_addr, 0);
        chk("rst_write", bus_if.bus_write, 0);
        chk("rst_wdata", bus_if.bus_wdata, 0);
        chk("rst_wstrb", bus_if.bus_wstrb, 0);
        nreset = 1'b1;

        // load from 0x100, ready two cycles after valid
        e_req = 1; e_addr = 32'h100; e_write = 0;
        e_wdata = 32'h1234_5678; e_wstrb = 4'hf;
        xfer(2, 0);
        chk("ld_cycles", last_cycles, 3);
        step();

        // store, payload scrambled while on the bus
        e_req = 1; e_addr = 32'h200; e_write = 1;
        e_wdata = 32'hDEAD_BEEF; e_wstrb = 4'b0011;
        xfer(2, 1);
        step();

        // timeout, then ready on the last allowed cycle
        e_req = 1; e_addr = 32'h300; e_write = 0;
        xfer(TMO + 1, 0);
        chk("tmo_cycles", last_cycles, TMO);
        chk("tmo_err", err, 1);
        step();
        e_req = 1; e_addr = 32'h304;
        xfer(TMO - 1, 0);
        chk("tie_cycles", last_cycles, TMO);
        chk("tie_err", err, 0);
        step();

        // new request presented on the done edge
        e_req = 1; e_addr = 32'h400;
        xfer(1, 0);
        e_req = 1; e_addr = 32'h404; e_write = 1;
        e_wdata = 32'h0BAD_F00D; e_wstrb = 4'b1100;
        step();
        xfer(0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk_quiet("nodup");
            step();
        end

        // both held: starvation guard ordering
        f_req = 1; f_addr = 32'h1001;
        e_req = 1; e_write = 0; e_addr = 32'h2000;
        for (int i = 0; i < 10; i++) begin
            xfer(0, 0);
            order[9-i] = last_win_e;
            if (last_win_e) begin
                e_req = 1; e_addr = e_addr + 4;
            end else begin
                f_req = 1; f_addr = f_addr + 4;
            end
            if (i < 9) step();
        end
        f_req = 0; e_req = 0;
        chk("grant_order", {22'h0, order}, 32'b1111011110);
        step();

        // reset in the middle of a transfer
        e_req = 1; e_addr = 32'h500; e_write = 0;
        chk_quiet("pre_rst");
        step();
        chk("mid_valid", bus_if.bus_valid, 1);
        nreset = 0; e_req = 0; f_req = 1; f_addr = 32'h3003;
        step();
        chk_quiet("mid_rst");
        nreset = 1;
        streak = 0;
        xfer(1, 0);
        chk("post_rst_fetch", last_win_e, 0);
        step();

        // random traffic
        for (int r = 0; r < 120; r++) begin
            if (!f_req && ($urandom_range(0, 2) != 0)) begin
                f_req = 1; f_addr = $urandom;
            end
            if (!e_req && ($urandom_range(0, 2) != 0)) begin
                e_req   = 1;
                e_addr  = $urandom;
                e_write = 1'($urandom);
                e_wdata = $urandom;
                e_wstrb = 4'($urandom);
            end
            if (!f_req && !e_req) begin
                chk_quiet("rnd_idle");
                step();
            end else begin
                int lat;
                lat = ($urandom_range(0, 7) == 0) ?
                      $urandom_range(6, 10) : $urandom_range(0, 3);
                xfer(lat, 1'($urandom));
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
